// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state, instruction class, ALU and jump-condition encodings for the 8-bit CPU
package cpu_pkg;
  typedef enum logic [2:0] {
    S_START, S_FETCH, S_DECODE, S_OPERAND, S_LOAD, S_STORE, S_ALU, S_HALT
  } state_t;
  localparam logic [1:0] CLS_ALU   = 2'b00;
  localparam logic [1:0] CLS_LOAD  = 2'b01;
  localparam logic [1:0] CLS_STORE = 2'b10;
  localparam logic [1:0] CLS_JUMP  = 2'b11;
  localparam logic [2:0] ALU_STOP = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;
  localparam logic [2:0] ALU_XOR  = 3'd5;
  localparam logic [1:0] JMP_ALWAYS = 2'd0;
  localparam logic [1:0] JMP_ZERO   = 2'd1;
  localparam logic [1:0] JMP_CARRY  = 2'd2;
  localparam logic [1:0] JMP_NEVER  = 2'd3;
  function automatic logic is_alu_op(input logic [2:0] s);
    return s inside {[ALU_ADD:ALU_XOR]};
  endfunction
endpackage

// File: rtl/cpu_ctrl_if.sv
// cpu_ctrl_if: memory request/ack bus between the control sequencer and memory
interface cpu_ctrl_if;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ack;
  modport master(output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
  modport slave(input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/cpu_pc.sv
// cpu_pc: 8-bit program counter, load has priority over increment
module cpu_pc #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       ld,
  input  logic [7:0] d,
  output logic [7:0] pc
);
  always_ff @(posedge clk)
    if (!rst) pc <= RESET_PC;
    else if (ld) pc <= d;
    else if (inc) pc <= pc + 8'd1;
endmodule

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: fetch/decode/execute sequencer owning PC, IR, operand latch and flags
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  cpu_ctrl_if.master       mem,
  input  logic [7:0]       reg_a,
  output logic             a_we,
  output logic             a_src,
  output logic             b_we,
  output logic [2:0]       alu_op,
  input  logic [7:0]       alu_result,
  input  logic             alu_carry,
  output logic             halted,
  output logic             flag_zero,
  output logic             flag_carry
);
  state_t     state, nxt;
  logic [7:3] ir;
  logic [7:0] opnd, pc;
  logic [1:0] cls;
  logic [2:0] sub;
  logic       ack, take, alu_do, ld_ack;
  assign cls    = ir[7:6];
  assign sub    = ir[5:3];
  assign ack    = mem.mem_req && mem.mem_ack;
  assign take   = sub[1:0] == JMP_ALWAYS || (sub[1:0] == JMP_ZERO && flag_zero) ||
                  (sub[1:0] == JMP_CARRY && flag_carry);
  assign alu_do = state == S_ALU && is_alu_op(sub);
  assign ld_ack = state == S_LOAD && ack;
  assign mem.mem_req   = state inside {S_FETCH, S_OPERAND, S_LOAD, S_STORE};
  assign mem.mem_we    = state == S_STORE;
  assign mem.mem_addr  = state inside {S_FETCH, S_OPERAND} ? pc :
                         state inside {S_LOAD, S_STORE} ? opnd : 8'h00;
  assign mem.mem_wdata = state == S_STORE ? reg_a : 8'h00;
  assign a_we   = alu_do || (ld_ack && !sub[0]);
  assign b_we   = ld_ack && sub[0];
  assign a_src  = alu_do;
  assign alu_op = alu_do ? sub : 3'd0;
  assign halted = state == S_HALT;
  cpu_pc #(.RESET_PC(RESET_PC)) u_pc (
    .clk(clk),
    .rst(rst),
    .inc(ack && state inside {S_FETCH, S_OPERAND}),
    .ld (ack && state == S_OPERAND && cls == CLS_JUMP && take),
    .d  (mem.mem_rdata),
    .pc (pc)
  );
  always_comb begin
    nxt = state;
    unique case (state)
      S_START:   nxt = S_FETCH;
      S_FETCH:   nxt = ack ? S_DECODE : S_FETCH;
      S_DECODE:  nxt = cls != CLS_ALU ? S_OPERAND : sub == ALU_STOP ? S_HALT : S_ALU;
      S_OPERAND: nxt = !ack ? S_OPERAND : cls == CLS_LOAD ? S_LOAD :
                       cls == CLS_STORE ? S_STORE : S_FETCH;
      S_LOAD:    nxt = ack ? S_FETCH : S_LOAD;
      S_STORE:   nxt = ack ? S_FETCH : S_STORE;
      S_ALU:     nxt = S_FETCH;
      S_HALT:    nxt = S_HALT;
      default:   nxt = S_START;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state      <= S_START;
      ir         <= '0;
      opnd       <= '0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_FETCH && ack) ir <= mem.mem_rdata[7:3];
      if (state == S_OPERAND && ack) opnd <= mem.mem_rdata;
      if (alu_do) begin
        flag_zero  <= alu_result == 8'h00;
        flag_carry <= (sub == ALU_ADD || sub == ALU_SUB) && alu_carry;
      end
    end
endmodule

// File: tb/tb_cpu_ctrl.sv
// tb_cpu_ctrl: directed programs against a memory/register model, checked by an event scoreboard
module tb_cpu_ctrl;
  import cpu_pkg::*;
  typedef struct packed {
    logic [1:0] kind;
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;
  logic clk = 1'b0, rst = 1'b0;
  logic a_we, a_src, b_we, halted, flag_zero, flag_carry;
  logic [2:0] alu_op;
  logic [7:0] ra = 8'h00, rb = 8'h00;
  logic [8:0] s;
  logic [7:0] mem [256];
  logic [1:0] cnt = 2'd0;
  logic rnd = 1'b0, block = 1'b0;
  ev_t q[$];
  int n_chk = 0, n_pass = 0;
  cpu_ctrl_if bus();
  cpu_ctrl #(.RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .mem(bus.master), .reg_a(ra), .a_we(a_we), .a_src(a_src),
    .b_we(b_we), .alu_op(alu_op), .alu_result(s[7:0]), .alu_carry(s[8]),
    .halted(halted), .flag_zero(flag_zero), .flag_carry(flag_carry)
  );
  always #5 clk = ~clk;
  assign bus.mem_rdata = mem[bus.mem_addr];
  assign bus.mem_ack = bus.mem_req && cnt == 2'd0 && !(block && bus.mem_addr == 8'h80);
  assign s = alu_op == ALU_ADD ? {1'b0, ra} + {1'b0, rb} :
             alu_op == ALU_SUB ? {1'b0, ra} - {1'b0, rb} :
             alu_op == ALU_AND ? {1'b0, ra & rb} :
             alu_op == ALU_OR  ? {1'b0, ra | rb} : {1'b0, ra ^ rb};
  always @(posedge clk) begin
    if (bus.mem_req && bus.mem_ack) cnt <= rnd ? 2'($urandom_range(0, 3)) : 2'd0;
    else if (bus.mem_req && cnt != 2'd0) cnt <= cnt - 2'd1;
    if (a_we) ra <= a_src ? s[7:0] : bus.mem_rdata;
    if (b_we) rb <= bus.mem_rdata;
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
  endtask
  task automatic pop_cmp(input ev_t g);
    ev_t e;
    if (q.size() == 0) begin
      n_chk++;
      $display("FAIL sb_unexpected got=%h exp=none at %0t", g, $time);
    end else begin
      e = q.pop_front();
      chk("sb_event", 32'(g), 32'(e));
    end
  endtask
  function automatic ev_t rd(input logic [7:0] a); return '{2'd0, 1'b0, a, 8'h00}; endfunction
  function automatic ev_t wr(input logic [7:0] a, input logic [7:0] d); return '{2'd0, 1'b1, a, d}; endfunction
  function automatic ev_t aw_mem(); return '{2'd1, 1'b0, 8'h00, 8'h00}; endfunction
  function automatic ev_t aw_alu(input logic [2:0] op); return '{2'd1, 1'b1, 8'h00, {5'd0, op}}; endfunction
  function automatic ev_t bw(); return '{2'd2, 1'b0, 8'h00, 8'h00}; endfunction
  logic       pend = 1'b0;
  logic [17:0] prev = '0;
  always @(negedge clk) begin
    if (!rst) pend = 1'b0;
    else begin
      if (pend)
        chk("req_stable", {14'd0, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata},
            {14'd0, prev});
      pend = bus.mem_req && !bus.mem_ack;
      prev = {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata};
      if (bus.mem_req && bus.mem_ack)
        pop_cmp('{2'd0, bus.mem_we, bus.mem_addr, bus.mem_we ? bus.mem_wdata : 8'h00});
      if (a_we) pop_cmp('{2'd1, a_src, 8'h00, a_src ? {5'd0, alu_op} : 8'h00});
      if (b_we) pop_cmp(bw());
    end
  end
  task automatic reset_dut();
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, a_we, b_we,
        a_src, alu_op, halted, flag_zero, flag_carry}, 32'd0);
    q.delete();
    rnd = 1'b0;
    block = 1'b0;
    foreach (mem[i]) mem[i] = 8'h00;
  endtask
  task automatic run(input string name, input int budget);
    int n = 0;
    while (!(halted && q.size() == 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_halted"}, 32'(halted), 32'd1);
    chk({name, "_drained"}, q.size(), 0);
  endtask
  task automatic prog2();
    mem[0] = 8'h40; mem[1] = 8'h80; mem[2] = 8'h48; mem[3] = 8'h81;
    mem[4] = 8'h08; mem[5] = 8'h80; mem[6] = 8'h82; mem[7] = 8'h00;
    mem[8'h80] = 8'hF0; mem[8'h81] = 8'h10; mem[8'h82] = 8'hAA;
    q.push_back(rd(0)); q.push_back(rd(1)); q.push_back(rd(8'h80)); q.push_back(aw_mem());
    q.push_back(rd(2)); q.push_back(rd(3)); q.push_back(rd(8'h81)); q.push_back(bw());
    q.push_back(rd(4)); q.push_back(aw_alu(ALU_ADD));
    q.push_back(rd(5)); q.push_back(rd(6)); q.push_back(wr(8'h82, 8'h00)); q.push_back(rd(7));
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    reset_dut();
    mem[0] = 8'h08; mem[1] = 8'h00;
    q.push_back(rd(0)); q.push_back(aw_alu(ALU_ADD)); q.push_back(rd(1));
    rst = 1'b1;
    @(negedge clk);
    chk("first_fetch", {bus.mem_req, bus.mem_we, bus.mem_addr}, {1'b1, 1'b0, 8'h00});
    repeat (2) @(negedge clk);
    chk("alu_strobe", {a_we, a_src, alu_op}, {1'b1, 1'b1, ALU_ADD});
    run("add", 50);
    reset_dut();
    prog2();
    rst = 1'b1;
    run("prog_zw", 100);
    chk("prog_zw_flags", {flag_zero, flag_carry}, 2'b11);
    reset_dut();
    prog2();
    rnd = 1'b1;
    rst = 1'b1;
    run("prog_wait", 300);
    chk("prog_wait_flags", {flag_zero, flag_carry}, 2'b11);
    reset_dut();
    mem[0] = 8'hC8; mem[1] = 8'h40;
    q.push_back(rd(0)); q.push_back(rd(1)); q.push_back(rd(2));
    rst = 1'b1;
    run("jz_not_taken", 50);
    reset_dut();
    mem[0] = 8'h48; mem[1] = 8'h90; mem[2] = 8'h18; mem[3] = 8'hC8; mem[4] = 8'h40;
    q.push_back(rd(0)); q.push_back(rd(1)); q.push_back(rd(8'h90)); q.push_back(bw());
    q.push_back(rd(2)); q.push_back(aw_alu(ALU_AND));
    q.push_back(rd(3)); q.push_back(rd(4)); q.push_back(rd(8'h40));
    rst = 1'b1;
    run("jz_taken", 80);
    chk("and_flags", {flag_zero, flag_carry}, 2'b10);
    reset_dut();
    mem[0] = 8'hD0; mem[1] = 8'h10; mem[2] = 8'h40; mem[3] = 8'h80; mem[4] = 8'h48;
    mem[5] = 8'h81; mem[6] = 8'h08; mem[7] = 8'hC0; mem[8] = 8'hFF; mem[8'hFF] = 8'h38;
    mem[8'h80] = 8'hF0; mem[8'h81] = 8'h10;
    q.push_back(rd(0)); q.push_back(rd(1)); q.push_back(rd(2)); q.push_back(rd(3));
    q.push_back(rd(8'h80)); q.push_back(aw_mem()); q.push_back(rd(4)); q.push_back(rd(5));
    q.push_back(rd(8'h81)); q.push_back(bw()); q.push_back(rd(6)); q.push_back(aw_alu(ALU_ADD));
    q.push_back(rd(7)); q.push_back(rd(8)); q.push_back(rd(8'hFF)); q.push_back(rd(0));
    q.push_back(rd(1)); q.push_back(rd(8'h10));
    rst = 1'b1;
    run("pc_wrap", 120);
    chk("nop_keeps_flags", {flag_zero, flag_carry}, 2'b11);
    reset_dut();
    for (int i = 0; i < 5; i++) mem[i] = 8'h30;
    for (int i = 0; i < 6; i++) q.push_back(rd(8'(i)));
    rst = 1'b1;
    run("stop", 60);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("halt_no_req", {bus.mem_req, halted}, 2'b01);
    end
    reset_dut();
    mem[0] = 8'h40; mem[1] = 8'h80; mem[8'h80] = 8'h5A;
    block = 1'b1;
    q.push_back(rd(0)); q.push_back(rd(1));
    rst = 1'b1;
    n = 0;
    while (!(bus.mem_req && bus.mem_addr == 8'h80) && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("load_pending", {bus.mem_req, bus.mem_we, bus.mem_addr}, {1'b1, 1'b0, 8'h80});
    rst = 1'b0;
    @(negedge clk);
    chk("req_drop_on_reset", {bus.mem_req, a_we, b_we}, 3'b000);
    chk("reset_drained", q.size(), 0);
    block = 1'b0;
    q.push_back(rd(0)); q.push_back(rd(1)); q.push_back(rd(8'h80)); q.push_back(aw_mem());
    q.push_back(rd(2));
    rst = 1'b1;
    @(negedge clk);
    chk("refetch_reset_pc", {bus.mem_req, bus.mem_addr}, {1'b1, 8'h00});
    run("after_reset", 60);
    chk("reg_a_loaded", ra, 8'h5A);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cpu_ctrl.md
# cpu_ctrl

Control sequencer for the 8-bit CPU. Owns the program counter (PC), instruction register (IR) and operand latch, and runs the fetch/decode/execute state machine. Drives the memory request handshake, the A/B register write strobes and the ALU opcode. Sits between the memory bus interface and the register/ALU datapath inside `cpu`.

## Interface
Parameters:
- `RESET_PC`, 8'h00: PC value loaded on reset.

Ports:
- `clk` in 1: single CPU clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `mem_req` out 1: memory request. Held until `mem_ack` is sampled high.
- `mem_we` out 1: 1 = write, 0 = read. Valid while `mem_req` is high.
- `mem_addr` out 8: request address.
- `mem_wdata` out 8: write data (value of `reg_a`).
- `mem_rdata` in 8: read data. Valid in the cycle `mem_ack` is high.
- `mem_ack` in 1: completes the request in the same cycle.
- `reg_a` in 8: current A register value.
- `a_we` out 1: write A this cycle.
- `a_src` out 1: A write source. 0 = `mem_rdata`, 1 = `alu_result`.
- `b_we` out 1: write B from `mem_rdata` this cycle.
- `alu_op` out 3: ALU function. Meaningful only when `a_we && a_src`.
- `alu_result` in 8: ALU result of A op B.
- `alu_carry` in 1: ALU carry/borrow out.
- `halted` out 1: high in HALT.
- `flag_zero` out 1: registered zero flag.
- `flag_carry` out 1: registered carry flag.

## Operation
Instruction byte layout: `[7:6]` class, `[5:3]` sub, `[2:0]` ignored.
- Class 00, ALU group. One byte. Sub values:
  - 000 STOP
  - 001 ADD
  - 010 SUB
  - 011 AND
  - 100 OR
  - 101 XOR
  - 110, 111: NOP
- Class 01, LOAD. Two bytes; the second byte is the address. `sub[0]` = 0 writes A, 1 writes B.
- Class 10, STORE. Two bytes. Writes A to the address.
- Class 11, JUMP. Two bytes; the second byte is the target. `sub[1:0]` selects the condition:
  - 00 always
  - 01 if `flag_zero`
  - 10 if `flag_carry`
  - 11 never

States and transitions:
- S_START: idle. Next state is S_FETCH.
- S_FETCH: read request at `mem_addr = PC`.
  - On ack: IR <= `mem_rdata`, PC <= PC+1, go to S_DECODE.
- S_DECODE:
  - Class 00, STOP: go to S_HALT.
  - Class 00, other sub: go to S_ALU.
  - Classes 01/10/11: go to S_OPERAND.
- S_OPERAND: read request at `mem_addr = PC`. On ack, PC <= PC+1, then by class:
  - JUMP: PC <= `mem_rdata` instead if the condition is true; go to S_FETCH.
  - LOAD/STORE: operand <= `mem_rdata`; go to S_LOAD or S_STORE respectively.
- S_LOAD: read request at `mem_addr = operand`. On ack, pulse `a_we` (with `a_src = 0`) or `b_we`, then go to S_FETCH.
- S_STORE: write request at `mem_addr = operand` with `mem_wdata = reg_a`. On ack, go to S_FETCH.
- S_ALU: for sub 001–101:
  - `a_we = 1`, `a_src = 1`, `alu_op = sub`.
  - `flag_zero` <= (`alu_result == 0`).
  - `flag_carry` <= `alu_carry` for ADD/SUB; cleared for AND/OR/XOR.
  - NOP: no write, flags unchanged.
  - Next state is S_FETCH.
- S_HALT: `halted = 1`, no requests. Left only via reset.

Rules:
- Arithmetic: PC increments mod 256, so 8'hFF wraps to 8'h00. This applies to both the fetch and the operand increment.
- Flags change only in S_ALU.

## Timing
Reset (`rst == 0` at an edge):
- state = S_START, PC = `RESET_PC`, IR = 0, operand = 0, flags = 0.
- All outputs are decoded from state and are low/zero in S_START: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `a_we`, `b_we`, `a_src`, `alu_op`, `halted`.
- Reset aborts any outstanding request; `mem_req` drops in the cycle after reset is sampled.

Memory handshake:
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` stay stable from assertion until the cycle `mem_ack` is high.
- `mem_ack` with `mem_req` low is ignored.
- Zero-wait memory means ack is high in the first request cycle.

Latency per instruction with zero-wait memory:
- ALU/NOP: 3 cycles (FETCH, DECODE, ALU).
- JUMP: 3 cycles.
- LOAD/STORE: 4 cycles.
- STOP: HALT is entered 2 cycles after fetch begins.
- Each wait state on memory adds 1 cycle per access.

Back-to-back requests: `mem_req` may stay high across consecutive accesses (for example S_OPERAND into S_LOAD). Each ack completes exactly one access.

## Structure
- Package `cpu_pkg` holds:
  - the `state_t` enum;
  - class constants `CLS_ALU`, `CLS_LOAD`, `CLS_STORE`, `CLS_JUMP`;
  - ALU sub encodings;
  - jump condition encodings.
- The ALU in `cpu` imports the same encodings.
- One sub-module, `cpu_pc`: 8-bit PC with synchronous active-low reset, increment enable and load enable. Load has priority over increment.

## Test plan
- Reset, then release with zero-wait memory holding 8'h08 (ADD) at address 0. Required:
  - `mem_req` rises 1 cycle after release with `mem_addr = 0`;
  - `a_we`/`a_src` high 3 cycles later with `alu_op = 001`.
- Program `LOAD A,0x80`; `LOAD B,0x81`; `ADD`; `STORE 0x82`, with mem[0x80] = 8'hF0 and mem[0x81] = 8'h10. Required:
  - a write to 0x82 with `mem_wdata` equal to the driven `reg_a` (8'h00);
  - `flag_zero = 1`, `flag_carry = 1`.
- Random 0–3 cycle ack delays on the same program. Required:
  - identical address/data sequence;
  - request signals stable while waiting.
- `JUMP` if zero to 0x40, with `flag_zero` both 0 and 1. Required: next fetch address is 0x02 or 0x40 respectively.
- PC at 8'hFF holding an ALU op. Required: next fetch at 8'h00.
- STOP at 0x05. Required:
  - `halted = 1` with no further requests;
  - reset asserted mid-LOAD (while `mem_req` is pending) returns to fetch from `RESET_PC`.
